// File: rtl/msk_and_hpc3_arb.sv
// Round-robin arbiter and sequencer sharing one external HPC3 masked-AND gadget
// (latency 1) between NREQ requesters, with a 2-entry result FIFO tagged by requester.
module msk_and_hpc3_arb #(
  parameter int d    = 2,
  parameter int NREQ = 2,
  localparam int RND = d * (d - 1),
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*d-1:0] req_a,
  input  logic [NREQ*d-1:0] req_b,
  input  logic [NREQ*d-1:0] req_c,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  input  logic [RND-1:0]    rnd_in,
  output logic [d-1:0]      g_ina,
  output logic [d-1:0]      g_inb,
  output logic [d-1:0]      g_inc,
  output logic [d-1:0]      g_ina_prev,
  output logic [RND-1:0]    g_rnd,
  input  logic [d-1:0]      g_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [d-1:0]      out_data,
  output logic [IW-1:0]     out_id
);

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   inflight_id;
  logic            found;
  logic            issue;
  logic            credit_ok;
  logic            pop;
  logic            inflight;
  logic [1:0]      count;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [NREQ-1:0] grant;
  logic [d-1:0]    fifo_data [2];
  logic [IW-1:0]   fifo_id   [2];

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!found && req_valid[k] && ((32'(rr_ptr) + off) % NREQ) == k) begin
          found  = 1'b1;
          winner = IW'(k);
        end
      end
    end
  end

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign credit_ok = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  // Gated by rst so nothing is granted while reset is asserted.
  assign issue     = !rst && found && rnd_valid && credit_ok;

  always_comb begin
    grant = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      grant[k] = issue && (winner == IW'(k));
    end
  end

  assign req_ready = grant;
  assign rnd_ready = issue;

  // AND-OR select keeps share i of the gadget input tied to share i of the winner.
  always_comb begin
    g_ina = '0;
    g_inb = '0;
    g_inc = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      g_ina = g_ina | ({d{grant[k]}} & req_a[k*d +: d]);
      g_inb = g_inb | ({d{grant[k]}} & req_b[k*d +: d]);
      g_inc = g_inc | ({d{grant[k]}} & req_c[k*d +: d]);
    end
  end

  assign g_rnd = issue ? rnd_in : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_id <= '0;
      g_ina_prev  <= '0;
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else begin
      g_ina_prev <= g_ina;
      inflight   <= issue;
      if (issue) begin
        inflight_id <= winner;
        rr_ptr      <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
      end
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) begin
      fifo_data[wr_ptr] <= g_out;
      fifo_id[wr_ptr]   <= inflight_id;
    end
  end

  assign out_data = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_id   = out_valid ? fifo_id[rd_ptr]   : '0;

endmodule
